// File: rtl/usb_host_poll_scheduler_if.sv
// -----------------------------------------------------------------------------
// usb_host_poll_scheduler_if : frame-timer / transceiver / SIPO side of the
// poll scheduler. Stats ports exist only with USB_SCHED_STATS_EN.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface usb_host_poll_scheduler_if #(
   parameter int NUM_DEV = 4
);
   logic                   frame_tick;
   logic [NUM_DEV-1:0]     dev_enable;
   logic [NUM_DEV*7-1:0]   dev_addr_flat;
   logic [NUM_DEV-1:0]     error_clear;
   logic                   tx_active;
   logic                   rx_valid;
   logic [3:0]             rx_pid;
   logic                   poll_start;
   logic [6:0]             poll_addr;
   logic [2:0]             poll_slot;
   logic                   sched_busy;
   logic                   slot_done;
   logic [1:0]             slot_status;
   logic [NUM_DEV-1:0]     dev_error;
   logic                   frame_overrun;
`ifdef USB_SCHED_STATS_EN
   logic [NUM_DEV*8-1:0]   nak_count;
   logic [NUM_DEV*8-1:0]   timeout_count;

   modport master (
      input  frame_tick, dev_enable, dev_addr_flat, error_clear,
             tx_active, rx_valid, rx_pid,
      output poll_start, poll_addr, poll_slot, sched_busy, slot_done,
             slot_status, dev_error, frame_overrun, nak_count, timeout_count
   );
   modport slave (
      output frame_tick, dev_enable, dev_addr_flat, error_clear,
             tx_active, rx_valid, rx_pid,
      input  poll_start, poll_addr, poll_slot, sched_busy, slot_done,
             slot_status, dev_error, frame_overrun, nak_count, timeout_count
   );
`else
   modport master (
      input  frame_tick, dev_enable, dev_addr_flat, error_clear,
             tx_active, rx_valid, rx_pid,
      output poll_start, poll_addr, poll_slot, sched_busy, slot_done,
             slot_status, dev_error, frame_overrun
   );
   modport slave (
      output frame_tick, dev_enable, dev_addr_flat, error_clear,
             tx_active, rx_valid, rx_pid,
      input  poll_start, poll_addr, poll_slot, sched_busy, slot_done,
             slot_status, dev_error, frame_overrun
   );
`endif
endinterface

`default_nettype wire

// File: rtl/usb_host_poll_scheduler.sv
// -----------------------------------------------------------------------------
// usb_host_poll_scheduler : per-frame round-robin poll of device slots with
// timeout/retry policy. Optional per-slot stats under USB_SCHED_STATS_EN.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module usb_host_poll_scheduler #(
   parameter int NUM_DEV        = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int MAX_RETRY      = 3,
   parameter int RETRY_GAP      = 16
) (
   input  wire logic                    clock,
   input  wire logic                    reset,
   usb_host_poll_scheduler_if.master    bus
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > RETRY_GAP) ? TIMEOUT_CYCLES : RETRY_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam int RTY_W   = $clog2(MAX_RETRY) + 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RETRY_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_ISSUE   = 3'd2,
      S_TX_WAIT = 3'd3,
      S_TX_RUN  = 3'd4,
      S_RX_WAIT = 3'd5,
      S_GAP     = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          ptr_q, ptr_d;
   logic [2:0]          slot_q, slot_d;
   logic [6:0]          addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RTY_W-1:0]    rty_q, rty_d;
   logic [1:0]          status_q, status_d;
   logic [NUM_DEV-1:0]  err_q, err_d;

   logic                found;
   logic [2:0]          found_idx;
   logic [6:0]          found_addr;
   logic                fail;
   logic                err_set;

   // Descending scan so the lowest eligible index at or above the pointer wins.
   always_comb begin
      found      = 1'b0;
      found_idx  = 3'd0;
      found_addr = 7'd0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         if ((4'(i) >= ptr_q) && bus.dev_enable[i] && !err_q[i]) begin
            found      = 1'b1;
            found_idx  = 3'(i);
            found_addr = bus.dev_addr_flat[i*7 +: 7];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      slot_d   = slot_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      rty_d    = rty_q;
      status_d = status_q;
      fail     = 1'b0;
      err_set  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.frame_tick) begin
               ptr_d   = 4'd0;
               state_d = S_SELECT;
            end
         end
         S_SELECT: begin
            if (found) begin
               slot_d  = found_idx;
               addr_d  = found_addr;
               rty_d   = '0;
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (bus.tx_active)        state_d = S_TX_RUN;
            else if (cnt_q >= TMO_LAST) fail  = 1'b1;
            else                      cnt_d   = cnt_q + 1'b1;
         end
         S_TX_RUN: begin
            if (!bus.tx_active) begin
               cnt_d   = '0;
               state_d = S_RX_WAIT;
            end
         end
         S_RX_WAIT: begin
            if (bus.rx_valid) begin
               case (bus.rx_pid)
                  4'b0011, 4'b1011: begin status_d = 2'b00; state_d = S_DONE; end
                  4'b1010:          begin status_d = 2'b01; state_d = S_DONE; end
                  4'b1110: begin
                     status_d = 2'b10;
                     err_set  = 1'b1;
                     state_d  = S_DONE;
                  end
                  default:          fail = 1'b1;
               endcase
            end else if (cnt_q >= TMO_LAST) begin
               fail = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q >= GAP_LAST) state_d = S_ISSUE;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         S_DONE: begin
            ptr_d   = {1'b0, slot_q} + 4'd1;
            state_d = S_SELECT;
         end
         default: state_d = S_IDLE;
      endcase

      if (fail) begin
         rty_d = (&rty_q) ? rty_q : rty_q + 1'b1;
         cnt_d = '0;
         if (int'(rty_q) + 1 < MAX_RETRY) begin
            state_d = S_GAP;
         end else begin
            status_d = 2'b11;
            err_set  = 1'b1;
            state_d  = S_DONE;
         end
      end
   end

   // Clear first, then set: only the current slot can be set in a given cycle.
   always_comb begin
      err_d = err_q & ~bus.error_clear;
      if (err_set) err_d = err_d | (NUM_DEV'(1) << slot_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ptr_q    <= 4'd0;
         slot_q   <= 3'd0;
         addr_q   <= 7'd0;
         cnt_q    <= '0;
         rty_q    <= '0;
         status_q <= 2'b00;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         slot_q   <= slot_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         rty_q    <= rty_d;
         status_q <= status_d;
         err_q    <= err_d;
      end
   end

   assign bus.poll_start    = (state_q == S_ISSUE);
   assign bus.poll_addr     = addr_q;
   assign bus.poll_slot     = slot_q;
   assign bus.sched_busy    = (state_q != S_IDLE);
   assign bus.slot_done     = (state_q == S_DONE);
   assign bus.slot_status   = (state_q == S_DONE) ? status_q : 2'b00;
   assign bus.dev_error     = err_q;
   assign bus.frame_overrun = bus.frame_tick && (state_q != S_IDLE);

`ifdef USB_SCHED_STATS_EN
   logic [7:0] nak_cnt_q [NUM_DEV];
   logic [7:0] nak_cnt_d [NUM_DEV];
   logic [7:0] to_cnt_q  [NUM_DEV];
   logic [7:0] to_cnt_d  [NUM_DEV];
   logic       nak_ev;

   assign nak_ev = (state_q == S_RX_WAIT) && bus.rx_valid && (bus.rx_pid == 4'b1010);

   always_comb begin
      for (int i = 0; i < NUM_DEV; i++) begin
         nak_cnt_d[i] = bus.error_clear[i] ? 8'h00 : nak_cnt_q[i];
         to_cnt_d[i]  = bus.error_clear[i] ? 8'h00 : to_cnt_q[i];
         if (nak_ev && (slot_q == 3'(i)) && (nak_cnt_d[i] != 8'hFF))
            nak_cnt_d[i] = nak_cnt_d[i] + 8'h01;
         if (fail && (slot_q == 3'(i)) && (to_cnt_d[i] != 8'hFF))
            to_cnt_d[i] = to_cnt_d[i] + 8'h01;
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_DEV; i++) begin
         if (reset) begin
            nak_cnt_q[i] <= 8'h00;
            to_cnt_q[i]  <= 8'h00;
         end else begin
            nak_cnt_q[i] <= nak_cnt_d[i];
            to_cnt_q[i]  <= to_cnt_d[i];
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_DEV; g++) begin : g_stats
         assign bus.nak_count[g*8 +: 8]     = nak_cnt_q[g];
         assign bus.timeout_count[g*8 +: 8] = to_cnt_q[g];
      end
   endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_host_poll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_usb_host_poll_scheduler : randomized rounds against a slot-level model of
// the poll schedule (expected starts, completions and error flags per round).
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_usb_host_poll_scheduler;

   localparam int NDEV = 4;
   localparam int TMO  = 64;
   localparam int RTRY = 3;
   localparam int GAP  = 16;

   // response kinds: 0 DATA0, 1 DATA1, 2 NAK, 3 STALL, 4 bad PID, 5 silent
   localparam int R_DATA0 = 0;
   localparam int R_DATA1 = 1;
   localparam int R_NAK   = 2;
   localparam int R_STALL = 3;
   localparam int R_BAD   = 4;
   localparam int R_NONE  = 5;

   logic clock;
   logic reset;

   usb_host_poll_scheduler_if #(.NUM_DEV(NDEV)) bus ();

   usb_host_poll_scheduler #(
      .NUM_DEV        (NDEV),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (RTRY),
      .RETRY_GAP      (GAP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec;
   int n_err;
   int cyc;
   int rnd;
   int ov_seen;
   int ph;
   bit xk;
   bit force_long;

   int         resp   [NDEV];
   logic [6:0] addr_m [NDEV];
   logic [NDEV-1:0] err_m;

   int exp_start_q [$];
   int exp_done_slot [$];
   int exp_done_stat [$];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] pid_for(input int kind);
      logic [3:0] p;
      case (kind)
         R_DATA0: p = 4'b0011;
         R_DATA1: p = 4'b1011;
         R_NAK:   p = 4'b1010;
         R_STALL: p = 4'b1110;
         default: begin
            p = 4'($urandom);
            while (p == 4'b0011 || p == 4'b1011 || p == 4'b1010 || p == 4'b1110)
               p = 4'($urandom);
         end
      endcase
      return p;
   endfunction

   // Transceiver + SIPO stand-in: reacts to poll_start with a tx burst and
   // then (optionally) a response PID.
   initial begin : xcvr
      int s, cnt, d2, d3, kind, last_slot, last_cyc, last_rnd;
      logic [3:0] pid;
      bus.tx_active = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_pid    = 4'h0;
      ph = 0; cnt = 0; d2 = 0; d3 = 0; kind = 0; pid = 4'h0;
      last_slot = -1; last_cyc = 0; last_rnd = -1;
      forever begin
         @(posedge clock); #1;
         bus.rx_valid = 1'b0;
         if (xk) begin
            ph = 0;
            bus.tx_active = 1'b0;
         end else begin
            case (ph)
               0: if (bus.poll_start) begin
                  chk("start_expected", exp_start_q.size() != 0, 1);
                  if (exp_start_q.size() != 0) begin
                     s = exp_start_q.pop_front();
                     chk("poll_slot", bus.poll_slot, s);
                     chk("poll_addr", bus.poll_addr, addr_m[s]);
                     if (s == last_slot && rnd == last_rnd)
                        chk("retry_gap", (cyc - last_cyc) >= GAP, 1);
                     last_slot = s; last_cyc = cyc; last_rnd = rnd;
                  end
                  kind = resp[bus.poll_slot];
                  pid  = pid_for(kind);
                  cnt  = $urandom_range(1, 5);
                  d2   = $urandom_range(1, 8);
                  d3   = force_long ? 40 : $urandom_range(1, 40);
                  ph   = 1;
               end
               1: begin
                  cnt--;
                  if (cnt == 0) begin bus.tx_active = 1'b1; cnt = d2; ph = 2; end
               end
               2: begin
                  cnt--;
                  if (cnt == 0) begin bus.tx_active = 1'b0; cnt = d3; ph = 3; end
               end
               default: begin
                  cnt--;
                  if (cnt == 0) begin
                     if (kind != R_NONE) begin
                        bus.rx_valid = 1'b1;
                        bus.rx_pid   = pid;
                     end
                     ph = 0;
                  end
               end
            endcase
         end
      end
   end

   initial begin : monitor
      int s, st;
      ov_seen = 0;
      forever begin
         @(negedge clock);
         if (!reset && bus.slot_done) begin
            chk("done_expected", exp_done_slot.size() != 0, 1);
            if (exp_done_slot.size() != 0) begin
               s  = exp_done_slot.pop_front();
               st = exp_done_stat.pop_front();
               chk("done_slot", bus.poll_slot, s);
               chk("slot_status", bus.slot_status, st);
            end
         end
         if (bus.frame_overrun) ov_seen++;
      end
   end

   task automatic build_model();
      for (int i = 0; i < NDEV; i++) begin
         if (bus.dev_enable[i] && !err_m[i]) begin
            case (resp[i])
               R_DATA0, R_DATA1: begin exp_start_q.push_back(i); exp_done_slot.push_back(i); exp_done_stat.push_back(0); end
               R_NAK:   begin exp_start_q.push_back(i); exp_done_slot.push_back(i); exp_done_stat.push_back(1); end
               R_STALL: begin exp_start_q.push_back(i); exp_done_slot.push_back(i); exp_done_stat.push_back(2); err_m[i] = 1'b1; end
               default: begin
                  for (int k = 0; k < RTRY; k++) exp_start_q.push_back(i);
                  exp_done_slot.push_back(i); exp_done_stat.push_back(3); err_m[i] = 1'b1;
               end
            endcase
         end
      end
   endtask

   task automatic flush_model();
      exp_start_q.delete();
      exp_done_slot.delete();
      exp_done_stat.delete();
   endtask

   task automatic drive_addrs();
      for (int i = 0; i < NDEV; i++) begin
         addr_m[i] = 7'($urandom);
         bus.dev_addr_flat[i*7 +: 7] = addr_m[i];
      end
   endtask

   task automatic run_round(input bit ovr);
      int t, exp_ov, n_done;
      bit empty;
      rnd++;
      exp_ov  = 0;
      ov_seen = 0;
      build_model();
      n_done = exp_done_slot.size();
      empty  = (n_done == 0);
      bus.frame_tick = 1'b1;
      @(posedge clock); #1;
      bus.frame_tick = 1'b0;
      chk("busy_after_tick", bus.sched_busy, 1);
      t = 0;
      while (bus.sched_busy && t < 4000) begin
         if (ovr && t == 7) begin
            bus.frame_tick = 1'b1;
            exp_ov = 1;
         end
         @(posedge clock); #1;
         bus.frame_tick = 1'b0;
         t++;
      end
      chk("round_timeout", t >= 4000, 0);
      if (empty) chk("empty_round_len", t, 1);
      repeat (3) @(posedge clock);
      #1;
      chk("no_extra_round", bus.sched_busy, 0);
      chk("starts_left", exp_start_q.size(), 0);
      chk("dones_left", exp_done_slot.size(), 0);
      chk("dev_error", bus.dev_error, err_m);
      chk("overrun_cnt", ov_seen, exp_ov);
      flush_model();
   endtask

   task automatic pulse_clear(input logic [NDEV-1:0] m);
      bus.error_clear = m;
      @(posedge clock); #1;
      bus.error_clear = '0;
      err_m = err_m & ~m;
      @(posedge clock); #1;
      chk("dev_error_clear", bus.dev_error, err_m);
   endtask

   task automatic check_idle_outputs(input string pfx);
      chk({pfx, "_poll_start"}, bus.poll_start, 0);
      chk({pfx, "_poll_addr"}, bus.poll_addr, 0);
      chk({pfx, "_poll_slot"}, bus.poll_slot, 0);
      chk({pfx, "_sched_busy"}, bus.sched_busy, 0);
      chk({pfx, "_slot_done"}, bus.slot_done, 0);
      chk({pfx, "_slot_status"}, bus.slot_status, 0);
      chk({pfx, "_dev_error"}, bus.dev_error, 0);
      chk({pfx, "_frame_overrun"}, bus.frame_overrun, 0);
   endtask

   initial begin : main
      int v, t;
      n_vec = 0; n_err = 0; cyc = 0; rnd = 0;
      xk = 1'b0; force_long = 1'b0; err_m = '0;
      reset = 1'b1;
      bus.frame_tick    = 1'b0;
      bus.dev_enable    = '0;
      bus.dev_addr_flat = '0;
      bus.error_clear   = '0;
      for (int i = 0; i < NDEV; i++) begin resp[i] = R_DATA0; addr_m[i] = 7'd0; end
      repeat (4) @(posedge clock);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;
      @(posedge clock); #1;

      for (int r = 0; r < 24; r++) begin
         drive_addrs();
         case (r)
            0: begin
               bus.dev_enable = 4'hF;
               for (int i = 0; i < NDEV; i++) resp[i] = R_DATA0;
            end
            1: begin
               bus.dev_enable = 4'b1010;
               for (int i = 0; i < NDEV; i++) resp[i] = R_DATA1;
            end
            2: begin
               bus.dev_enable = 4'hF;
               resp[0] = R_NAK; resp[1] = R_STALL; resp[2] = R_NONE; resp[3] = R_DATA1;
            end
            default: begin
               bus.dev_enable = NDEV'($urandom);
               for (int i = 0; i < NDEV; i++) begin
                  v = $urandom_range(0, 9);
                  resp[i] = (v < 3) ? R_DATA0 : (v < 5) ? R_DATA1 : (v < 7) ? R_NAK :
                            (v == 7) ? R_STALL : (v == 8) ? R_BAD : R_NONE;
               end
            end
         endcase
         run_round(r % 3 == 1);
         if (r % 4 == 3) pulse_clear(NDEV'($urandom));
      end

      // Reset during RX_WAIT: first leave a known error bit behind.
      pulse_clear('1);
      drive_addrs();
      bus.dev_enable = 4'b0010;
      resp[1] = R_STALL;
      run_round(1'b0);
      drive_addrs();
      bus.dev_enable = 4'hF;
      for (int i = 0; i < NDEV; i++) resp[i] = R_DATA0;
      force_long = 1'b1;
      rnd++;
      build_model();
      bus.frame_tick = 1'b1;
      @(posedge clock); #1;
      bus.frame_tick = 1'b0;
      t = 0;
      while (ph != 3 && t < 500) begin
         @(posedge clock); #1;
         t++;
      end
      chk("reach_rx_wait", t < 500, 1);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      xk    = 1'b1;
      @(posedge clock); #1;
      check_idle_outputs("midreset");
      reset = 1'b0;
      @(posedge clock); #1;
      xk = 1'b0;
      force_long = 1'b0;
      flush_model();
      err_m = '0;
      @(posedge clock); #1;
      drive_addrs();
      run_round(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/usb_host_poll_scheduler.md
Name: usb_host_poll_scheduler

Overview:
- Sequences the host-side USB transceiver through periodic polling rounds across up to NUM_DEV downstream device slots.
- Each slot is served in turn: start the transceiver's poll, track its request phase, wait for the device response PID, apply timeout/retry policy, then advance to the next slot.
- Sits between the frame timer and the transceiver/SIPO pair. Owns the transceiver's polling pulse and the address it transmits.

Parameters:
- NUM_DEV, 4, number of device slots polled per round (1..8)
- TIMEOUT_CYCLES, 64, max clock cycles waited for tx start or response PID
- MAX_RETRY, 3, attempts per slot before declaring timeout
- RETRY_GAP, 16, idle cycles inserted between retry attempts

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_tick  input  1  one-cycle pulse, starts a polling round
- dev_enable  input  NUM_DEV  slot enable mask
- dev_addr_flat  input  NUM_DEV*7  7-bit USB address per slot; slot i at [7i+6:7i]
- error_clear  input  NUM_DEV  one-cycle pulse per bit, clears dev_error bit
- tx_active  input  1  transceiver driving_req
- rx_valid  input  1  one-cycle pulse, rx_pid valid
- rx_pid  input  4  received PID nibble
- poll_start  output  1  one-cycle pulse to transceiver polling input
- poll_addr  output  7  address of current slot; stable from poll_start to slot_done
- poll_slot  output  3  index of current slot
- sched_busy  output  1  high from round start to round end
- slot_done  output  1  one-cycle completion pulse per served slot
- slot_status  output  2  valid with slot_done: 00 DATA, 01 NAK, 10 STALL, 11 TIMEOUT
- dev_error  output  NUM_DEV  sticky per-slot error flags
- frame_overrun  output  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; retry and timeout counters 0.
- States: IDLE, SELECT, ISSUE, TX_WAIT, TX_RUN, RX_WAIT, GAP, DONE.
- IDLE: on frame_tick, go to SELECT with slot pointer 0 and sched_busy=1.
- SELECT: scan from the pointer for the first slot with dev_enable=1 and dev_error=0.
  - Found: latch poll_slot and poll_addr, clear retry_cnt, go to ISSUE.
  - None left: sched_busy=0, go to IDLE. A round with no eligible slot therefore ends in 2 cycles.
- ISSUE: poll_start=1 for exactly one cycle; go to TX_WAIT.
- TX_WAIT: wait for tx_active=1.
  - If it does not rise within TIMEOUT_CYCLES, treat as an attempt failure.
- TX_RUN: when tx_active falls, reset the timeout counter and go to RX_WAIT.
- RX_WAIT: on rx_valid, decode rx_pid:
  - 0011 or 1011 (DATA0/1): status 00.
  - 1010: status 01 (NAK).
  - 1110: status 10 (STALL); also sets dev_error[slot].
  - Any other PID, or counter reaching TIMEOUT_CYCLES: attempt failure.
  - rx_valid outside RX_WAIT is ignored.
- Attempt failure: retry_cnt+1.
  - If the new count is below MAX_RETRY, go to GAP; after RETRY_GAP cycles, go to ISSUE.
  - Otherwise status 11 (TIMEOUT), set dev_error[slot], go to DONE.
- DONE: slot_done=1 for one cycle; pointer = slot+1; go to SELECT.
- Counters saturate and never wrap. Counter width is clog2(max(TIMEOUT_CYCLES, RETRY_GAP))+1.
- frame_tick while sched_busy=1: pulse frame_overrun the same cycle; the tick is otherwise dropped (not queued).
- Clear vs set: error_clear wins over a same-cycle set for other slots. For the current slot, a same-cycle set wins.
- dev_enable is sampled only in SELECT. Deasserting the current slot mid-transaction does not abort it.
- Reset mid-transaction: return to IDLE immediately; dev_error is cleared.

Optional Feature:
- Macro: USB_SCHED_STATS_EN.
- When defined:
  - Adds output nak_count (NUM_DEV*8 bits): a per-slot 8-bit saturating NAK counter.
  - Adds output timeout_count (NUM_DEV*8 bits): a per-slot 8-bit saturating count of attempt failures.
  - Both counters are cleared by reset and by the slot's error_clear bit.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Slots 0–3 enabled, model answers DATA0 (0011) 10 cycles after tx_active falls -> four poll_start pulses in order; poll_addr matches each slot's address; four slot_done pulses with status 00; sched_busy then drops.
- dev_enable=4'b1010 -> only slots 1 and 3 polled; no poll_start for slots 0/2.
- Slot 2 never responds, TIMEOUT_CYCLES=64, MAX_RETRY=3 -> three poll_start pulses for slot 2, each ≥16 cycles apart; status 11; dev_error[2]=1; next round skips slot 2 until error_clear[2].
- Slot 0 answers NAK (1010), slot 1 answers STALL (1110) -> status 01 with no retry; status 10 with dev_error[1]=1.
- frame_tick during an active round -> frame_overrun pulses once; the round is uninterrupted; no extra round starts.
- Reset asserted during RX_WAIT -> all outputs 0 on the next cycle; a fresh frame_tick restarts from slot 0.
